// File: rtl/cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : cond_flag_unit
// Purpose  : Execute-stage NZCV flag register, condition check, write-enable
//            gating and the register into the writeback stage.
// Revision : 1.0 - initial release
// ============================================================================
module cond_flag_unit #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             En,
  input  logic             Flush,
  input  logic [3:0]       Cond,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic             Zero,
  input  logic             Negative,
  input  logic             Carry,
  input  logic             Overflow,
  input  logic [WIDTH-1:0] ResultIn,
  input  logic [RD_W-1:0]  RdIn,
  output logic             CondEx,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic             WbValid,
  output logic [WIDTH-1:0] WbResult,
  output logic [RD_W-1:0]  WbRd
);

  localparam logic [3:0] c_cond_eq = 4'b0000;
  localparam logic [3:0] c_cond_ne = 4'b0001;
  localparam logic [3:0] c_cond_cs = 4'b0010;
  localparam logic [3:0] c_cond_cc = 4'b0011;
  localparam logic [3:0] c_cond_mi = 4'b0100;
  localparam logic [3:0] c_cond_pl = 4'b0101;
  localparam logic [3:0] c_cond_vs = 4'b0110;
  localparam logic [3:0] c_cond_vc = 4'b0111;
  localparam logic [3:0] c_cond_hi = 4'b1000;
  localparam logic [3:0] c_cond_ls = 4'b1001;
  localparam logic [3:0] c_cond_ge = 4'b1010;
  localparam logic [3:0] c_cond_lt = 4'b1011;
  localparam logic [3:0] c_cond_gt = 4'b1100;
  localparam logic [3:0] c_cond_le = 4'b1101;
  localparam logic [3:0] c_cond_al = 4'b1110;

  logic [3:0]       flags_q,     flags_d;
  logic             wb_valid_q,  wb_valid_d;
  logic [WIDTH-1:0] wb_result_q, wb_result_d;
  logic [RD_W-1:0]  wb_rd_q,     wb_rd_d;

  logic w_n, w_z, w_c, w_v;
  logic w_cond_ex;
  logic w_flag_upd;

  assign w_n = flags_q[3];
  assign w_z = flags_q[2];
  assign w_c = flags_q[1];
  assign w_v = flags_q[0];

  // Only the stored flags are consulted, so an instruction never sees its own update.
  always_comb begin
    w_cond_ex = 1'b0;
    case (Cond)
      c_cond_eq: w_cond_ex = w_z;
      c_cond_ne: w_cond_ex = ~w_z;
      c_cond_cs: w_cond_ex = w_c;
      c_cond_cc: w_cond_ex = ~w_c;
      c_cond_mi: w_cond_ex = w_n;
      c_cond_pl: w_cond_ex = ~w_n;
      c_cond_vs: w_cond_ex = w_v;
      c_cond_vc: w_cond_ex = ~w_v;
      c_cond_hi: w_cond_ex = w_c & ~w_z;
      c_cond_ls: w_cond_ex = ~w_c | w_z;
      c_cond_ge: w_cond_ex = (w_n == w_v);
      c_cond_lt: w_cond_ex = (w_n != w_v);
      c_cond_gt: w_cond_ex = ~w_z & (w_n == w_v);
      c_cond_le: w_cond_ex = w_z | (w_n != w_v);
      c_cond_al: w_cond_ex = 1'b1;
      default:   w_cond_ex = 1'b0;
    endcase
  end

  assign CondEx   = w_cond_ex;
  assign PCSrc    = PCS & w_cond_ex;
  assign RegWrite = RegW & w_cond_ex & ~NoWrite;
  assign MemWrite = MemW & w_cond_ex;

  assign w_flag_upd = En & ~Flush & w_cond_ex;

  always_comb begin
    flags_d = flags_q;
    if (w_flag_upd && FlagW[1]) begin
      flags_d[3] = Negative;
      flags_d[2] = Zero;
    end
    if (w_flag_upd && FlagW[0]) begin
      flags_d[1] = Carry;
      flags_d[0] = Overflow;
    end
  end

  // Flush kills the slot but leaves the data fields as they were.
  always_comb begin
    wb_valid_d  = wb_valid_q;
    wb_result_d = wb_result_q;
    wb_rd_d     = wb_rd_q;
    if (Flush) begin
      wb_valid_d = 1'b0;
    end else if (En) begin
      wb_valid_d  = RegWrite;
      wb_result_d = ResultIn;
      wb_rd_d     = RdIn;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q     <= 4'b0000;
      wb_valid_q  <= 1'b0;
      wb_result_q <= '0;
      wb_rd_q     <= '0;
    end else begin
      flags_q     <= flags_d;
      wb_valid_q  <= wb_valid_d;
      wb_result_q <= wb_result_d;
      wb_rd_q     <= wb_rd_d;
    end
  end

  assign Flags    = flags_q;
  assign WbValid  = wb_valid_q;
  assign WbResult = wb_result_q;
  assign WbRd     = wb_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cond_flag_unit
// Purpose  : Directed and randomized checks of cond_flag_unit against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cond_flag_unit;

  localparam int WIDTH = 32;
  localparam int RD_W  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             En, Flush, PCS, RegW, MemW, NoWrite;
  logic             Zero, Negative, Carry, Overflow;
  logic [3:0]       Cond;
  logic [1:0]       FlagW;
  logic [WIDTH-1:0] ResultIn;
  logic [RD_W-1:0]  RdIn;
  logic             CondEx, PCSrc, RegWrite, MemWrite, WbValid;
  logic [3:0]       Flags;
  logic [WIDTH-1:0] WbResult;
  logic [RD_W-1:0]  WbRd;

  int tests = 0;
  int fails = 0;

  logic [3:0]       m_flags;
  logic             m_wbv;
  logic [WIDTH-1:0] m_wbr;
  logic [RD_W-1:0]  m_wbrd;

  cond_flag_unit #(.WIDTH(WIDTH), .RD_W(RD_W)) dut (
    .clk(clk), .reset(reset), .En(En), .Flush(Flush), .Cond(Cond), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .Zero(Zero),
    .Negative(Negative), .Carry(Carry), .Overflow(Overflow), .ResultIn(ResultIn),
    .RdIn(RdIn), .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .Flags(Flags), .WbValid(WbValid), .WbResult(WbResult),
    .WbRd(WbRd)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Condition pairs: even code tests a predicate, odd code its negation; 1111 never runs.
  function automatic bit model_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    return base ^ c[0];
  endfunction

  task automatic model_reset();
    m_flags = 4'b0000; m_wbv = 1'b0; m_wbr = '0; m_wbrd = '0;
  endtask

  task automatic step();
    bit ce;
    ce = model_cond(Cond, m_flags);
    if (Flush) begin
      m_wbv = 1'b0;
    end else if (En) begin
      m_wbv  = RegW && ce && !NoWrite;
      m_wbr  = ResultIn;
      m_wbrd = RdIn;
      if (ce && FlagW[1]) begin m_flags[3] = Negative; m_flags[2] = Zero; end
      if (ce && FlagW[0]) begin m_flags[1] = Carry;    m_flags[0] = Overflow; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    En = 1'b1; Flush = 1'b0; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
    Zero = 1'b0; Negative = 1'b0; Carry = 1'b0; Overflow = 1'b0;
    Cond = 4'b1110; FlagW = 2'b00; ResultIn = '0; RdIn = '0;
  endtask

  task automatic load_flags(input logic [3:0] f);
    Negative = f[3]; Zero = f[2]; Carry = f[1]; Overflow = f[0];
    Cond = 4'b1110; FlagW = 2'b11; En = 1'b1; Flush = 1'b0;
    step();
    FlagW = 2'b00;
  endtask

  task automatic check_cond(input string name, input logic [3:0] c, input logic exp);
    Cond = c;
    #1;
    tests++;
    if (CondEx !== exp) begin
      fails++;
      $display("FAIL %s: CondEx=%b required=%b (Flags=%b)", name, CondEx, exp, Flags);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    #3;
    tests++;
    if (Flags !== 4'b0000 || WbValid !== 1'b0 || WbResult !== '0 || WbRd !== '0) begin
      fails++;
      $display("FAIL power_on_reset: Flags=%b WbValid=%b WbResult=%h WbRd=%h required=0",
               Flags, WbValid, WbResult, WbRd);
    end
    #4 reset = 1'b0;
    model_reset();
    RegW = 1'b1; ResultIn = 32'h1234_5678; RdIn = 4'hA;
    load_flags(4'b1111);
    RegW = 1'b0;
    tests++;
    if (Flags !== 4'b1111 || WbValid !== 1'b1) begin
      fails++;
      $display("FAIL preset: Flags=%b WbValid=%b required 1111/1", Flags, WbValid);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (Flags !== 4'b0000 || WbValid !== 1'b0 || WbResult !== '0 || WbRd !== '0) begin
      fails++;
      $display("FAIL async_reset: Flags=%b WbValid=%b WbResult=%h WbRd=%h required=0",
               Flags, WbValid, WbResult, WbRd);
    end
    model_reset();
    check_cond("reset_eq", 4'b0000, 1'b0);
    check_cond("reset_al", 4'b1110, 1'b1);
    reset = 1'b0;
  endtask

  task automatic test_flag_set();
    idle_inputs();
    load_flags(4'b0100);
    tests++;
    if (Flags !== 4'b0100) begin
      fails++;
      $display("FAIL full_set: Flags=%b required=0100", Flags);
    end
    check_cond("set_eq", 4'b0000, 1'b1);
    check_cond("set_ne", 4'b0001, 1'b0);
  endtask

  task automatic test_partial();
    idle_inputs();
    Negative = 1'b1; Zero = 1'b0; Carry = 1'b1; Overflow = 1'b1;
    FlagW = 2'b10;
    step();
    tests++;
    if (Flags !== 4'b1000) begin
      fails++;
      $display("FAIL partial_nz: Flags=%b required=1000", Flags);
    end
    FlagW = 2'b01;
    step();
    tests++;
    if (Flags !== 4'b1011) begin
      fails++;
      $display("FAIL partial_cv: Flags=%b required=1011", Flags);
    end
  endtask

  task automatic test_suppress();
    idle_inputs();
    load_flags(4'b0000);
    Cond = 4'b0000; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; FlagW = 2'b11;
    Negative = 1'b1; Zero = 1'b1; Carry = 1'b1; Overflow = 1'b1;
    #1;
    tests++;
    if (PCSrc !== 1'b0 || RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
      fails++;
      $display("FAIL suppress_en: PCSrc=%b RegWrite=%b MemWrite=%b required 000",
               PCSrc, RegWrite, MemWrite);
    end
    step();
    tests++;
    if (Flags !== 4'b0000 || WbValid !== 1'b0) begin
      fails++;
      $display("FAIL suppress_state: Flags=%b WbValid=%b required 0000/0", Flags, WbValid);
    end
    FlagW = 2'b00; NoWrite = 1'b1; Cond = 4'b1110;
    #1;
    tests++;
    if (RegWrite !== 1'b0 || MemWrite !== 1'b1 || PCSrc !== 1'b1) begin
      fails++;
      $display("FAIL nowrite: RegWrite=%b MemWrite=%b PCSrc=%b required 0/1/1",
               RegWrite, MemWrite, PCSrc);
    end
    MemW = 1'b0;
    #1;
    tests++;
    if (MemWrite !== 1'b0) begin
      fails++;
      $display("FAIL memw_off: MemWrite=%b required=0", MemWrite);
    end
  endtask

  task automatic test_signed();
    idle_inputs();
    load_flags(4'b1000);
    check_cond("ge_1000", 4'b1010, 1'b0);
    check_cond("lt_1000", 4'b1011, 1'b1);
    check_cond("gt_1000", 4'b1100, 1'b0);
    check_cond("le_1000", 4'b1101, 1'b1);
    check_cond("nv_1000", 4'b1111, 1'b0);
    Overflow = 1'b1; Carry = 1'b0; FlagW = 2'b01; Cond = 4'b1110;
    step();
    FlagW = 2'b00;
    tests++;
    if (Flags !== 4'b1001) begin
      fails++;
      $display("FAIL set_1001: Flags=%b required=1001", Flags);
    end
    check_cond("ge_1001", 4'b1010, 1'b1);
    check_cond("gt_1001", 4'b1100, 1'b1);
    check_cond("hi_1001", 4'b1000, 1'b0);
  endtask

  task automatic test_stall_flush();
    logic [3:0]       f0;
    logic [WIDTH-1:0] r0;
    idle_inputs();
    RegW = 1'b1; ResultIn = 32'h0BAD_F00D; RdIn = 4'h3;
    step();
    f0 = Flags; r0 = WbResult;
    tests++;
    if (WbValid !== 1'b1 || WbResult !== 32'h0BAD_F00D || WbRd !== 4'h3) begin
      fails++;
      $display("FAIL wb_load: WbValid=%b WbResult=%h WbRd=%h required 1/0badf00d/3",
               WbValid, WbResult, WbRd);
    end
    En = 1'b0; ResultIn = 32'hDEAD_BEEF; RdIn = 4'h7; FlagW = 2'b11;
    Negative = ~f0[3]; Zero = ~f0[2]; Carry = ~f0[1]; Overflow = ~f0[0];
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (WbResult !== r0 || WbValid !== 1'b1 || Flags !== f0 || WbRd !== 4'h3) begin
        fails++;
        $display("FAIL stall_%0d: WbResult=%h WbValid=%b Flags=%b required %h/1/%b",
                 i, WbResult, WbValid, Flags, r0, f0);
      end
    end
    En = 1'b1; Flush = 1'b1;
    step();
    tests++;
    if (WbValid !== 1'b0 || Flags !== f0 || WbResult !== r0) begin
      fails++;
      $display("FAIL flush: WbValid=%b Flags=%b WbResult=%h required 0/%b/%h",
               WbValid, Flags, WbResult, f0, r0);
    end
    Flush = 1'b0; FlagW = 2'b00;
    step();
    tests++;
    if (WbValid !== 1'b1 || WbResult !== 32'hDEAD_BEEF || WbRd !== 4'h7) begin
      fails++;
      $display("FAIL after_flush: WbValid=%b WbResult=%h WbRd=%h required 1/deadbeef/7",
               WbValid, WbResult, WbRd);
    end
  endtask

  task automatic test_x_cond();
    logic [3:0] f0;
    idle_inputs();
    f0 = Flags;
    Cond = 4'bxxxx; FlagW = 2'b00;
    step();
    tests++;
    if (Flags !== f0 || WbValid !== 1'b0) begin
      fails++;
      $display("FAIL x_cond: Flags=%b WbValid=%b required %b/0", Flags, WbValid, f0);
    end
  endtask

  task automatic test_random();
    bit ce;
    for (int i = 0; i < 500; i++) begin
      En = ($urandom_range(0, 7) != 0); Flush = ($urandom_range(0, 9) == 0);
      Cond = 4'($urandom); FlagW = 2'($urandom);
      PCS = 1'($urandom); RegW = 1'($urandom); MemW = 1'($urandom);
      NoWrite = ($urandom_range(0, 3) == 0);
      Zero = 1'($urandom); Negative = 1'($urandom);
      Carry = 1'($urandom); Overflow = 1'($urandom);
      ResultIn = $urandom; RdIn = 4'($urandom);
      #1;
      ce = model_cond(Cond, m_flags);
      tests++;
      if (CondEx !== ce || PCSrc !== (PCS & ce) || MemWrite !== (MemW & ce) ||
          RegWrite !== (RegW & ce & ~NoWrite)) begin
        fails++;
        $display("FAIL rand_comb[%0d]: Cond=%b Flags=%b CondEx=%b PCSrc=%b RegWrite=%b MemWrite=%b required CondEx=%b",
                 i, Cond, Flags, CondEx, PCSrc, RegWrite, MemWrite, ce);
      end
      step();
      tests++;
      if (Flags !== m_flags || WbValid !== m_wbv || WbResult !== m_wbr || WbRd !== m_wbrd) begin
        fails++;
        $display("FAIL rand_state[%0d]: Flags=%b WbValid=%b WbResult=%h WbRd=%h required %b/%b/%h/%h",
                 i, Flags, WbValid, WbResult, WbRd, m_flags, m_wbv, m_wbr, m_wbrd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_flag_set();
    test_partial();
    test_suppress();
    test_signed();
    test_stall_flush();
    test_x_cond();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
